mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's byte-wide memory bus (`mem_a`/`mem_wr`/`mem_dout`/`mem_din`).
- Serves RAM reads with registered one-cycle latency and RAM writes in one cycle.
- Decodes the I/O window at `mem_a[17:16]==2'b11`: UART input/output byte queues, a free-running cycle counter and the program-stop port.
- Drives the CPU's `rdy_in` to apply back-pressure when the output queue is full or a stop is pending.

## Interface
Parameters:
- `RAM_ADDR_W`, 17 — RAM byte-address width (128 KB).
- `IN_DEPTH`, 16 — input byte queue depth (power of 2).
- `OUT_DEPTH`, 16 — output byte queue depth (power of 2).

Ports:
- `clk_in` in 1 — single clock.
- `rst_in` in 1 — synchronous, active-high reset.
- `mem_a` in 32 — CPU address; only bits 17:0 are decoded.
- `mem_wr` in 1 — 1 = write, 0 = read.
- `mem_dout` in 8 — CPU write data.
- `mem_din` out 8 — read data to the CPU.
- `rdy_out` out 1 — to CPU `rdy_in`; bus is sampled only when 1.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1 — input byte stream.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1 — output byte stream.
- `prog_stop` out 1 — program finished and output drained.

## Operation
- **Bus transaction:** a cycle is a transaction when `rdy_out=1` and `rst_in=0`. In all other cycles `mem_a`, `mem_wr` and `mem_dout` are ignored.
- **Decode:**
  - `io = (mem_a[17:16]==2'b11)`; otherwise RAM at `mem_a[RAM_ADDR_W-1:0]`.
  - 0x20000–0x2FFFF alias onto RAM.
- **RAM:**
  - A write updates the byte at the edge.
  - A read registers the byte into `mem_din`.
  - RAM contents are not reset.
- **I/O read 0x30000:** pops the input queue head into `mem_din`. When the queue is empty, returns 0x00 with no pop.
- **I/O read 0x30004:**
  - Returns `cnt[7:0]` and snapshots `cnt[31:8]` into `snap`.
  - Reads of 0x30005/6/7 return `snap` bytes 1/2/3, giving a coherent 32-bit read.
- **I/O write 0x30000:** pushes `mem_dout` to the output queue; 0x00 is discarded.
- **I/O write 0x30004:**
  - Pushes 0x00 to the output queue (bypassing the null filter).
  - Sets sticky `stop_pend`.
- **Other I/O offsets:** reads return 0x00; writes are ignored.
- **Cycle counter `cnt`:** +1 every clock out of reset, independent of `rdy_out`; wraps at 2^32.
- **Handshakes:**
  - `rdy_out = !out_full && !stop_pend`.
  - `rx_ready = !in_full`; push on `rx_valid && rx_ready`.
  - `tx_valid = !out_empty`, `tx_data` = head; pop on `tx_valid && tx_ready`.
- **`prog_stop`:** registered; rises the cycle after `stop_pend && out_empty`. Sticky until reset.
- **Boundary conditions:**
  - Input push and CPU pop in the same cycle on an empty queue: the read returns 0x00 and the pushed byte is retained.
  - Push and pop in the same cycle on a non-empty queue: occupancy is unchanged.
  - A write arriving at occupancy `OUT_DEPTH-1` is accepted. `rdy_out` drops the next cycle.
  - `tx_ready` pop with a simultaneous CPU push while full: cannot occur, because `rdy_out=0` when full.

## Timing
- **Read latency:** address and `mem_wr=0` in cycle N → `mem_din` valid in cycle N+1. `mem_din` then holds until the next read transaction.
- **Write:** takes effect at the end of cycle N; a read of the same address in N+1 returns the new value.
- **Back-pressure:** `rdy_out` is combinational from registered state, so it changes only after an edge.
- **Reset values:**
  - `mem_din` = 0x00.
  - `cnt` = 0, `snap` = 0.
  - Both queues empty, so `rx_ready=1`, `tx_valid=0`, `tx_data=0x00`.
  - `stop_pend=0`, `prog_stop=0`.
  - `rdy_out=1` from the first cycle after reset deasserts.
- **Reset mid-operation:**
  - An in-flight read is discarded (`mem_din`=0x00 next cycle).
  - Queued bytes are lost.
  - A pending stop is cleared.

## Structure
- **Package `mem_resp_pkg`:**
  - Constants `IO_SEL=2'b11`, `IO_UART=18'h30000`, `IO_CLK=18'h30004`.
  - Byte-select helper for the counter snapshot.
- **Sub-module `byte_fifo`:**
  - Parameterized depth; synchronous reset.
  - Ports: push/pop, `empty`/`full`, head data (first-word fall-through).
  - Instantiated twice (input queue, output queue).
- **Top:** holds the RAM array, decode, read register, counter, snapshot and stop logic.

## Test plan
- **RAM:** write 0xA5 @0x00100, then read @0x00100 → `mem_din`=0xA5 exactly one cycle after the read. A read @0x20100 also returns 0xA5 (alias).
- **UART input:**
  - Push rx bytes 0x41, 0x42, then CPU reads 0x30000 ×3 → 0x41, 0x42, 0x00.
  - Fill `IN_DEPTH` bytes → `rx_ready`=0.
- **UART output:**
  - With `tx_ready`=0, write 0x00 then 0x31 ×16 to 0x30000 → `tx_data`=0x31 and the 0x00 is never queued.
  - `rdy_out`=0 after the 16th write; CPU `mem_wr` pulses while `rdy_out`=0 leave the count unchanged.
- **Counter:** read 0x30004..0x30007 with `cnt`=0x000000FF at the first read → returns 0xFF, 0x00, 0x00, 0x00 despite the increments during the sequence.
- **Stop:**
  - Queue 0x48, then write 0x30004 → `rdy_out`=0 immediately after.
  - `tx` emits 0x48, 0x00; `prog_stop`=1 one cycle after the queue empties.
- **Reset mid-read:** assert `rst_in` in the cycle after a read → `mem_din`=0x00, queues empty, `cnt` restarts from 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared constants, bus-access classification and helpers for the
// memory-side responder.
//   IO_SEL     : value of mem_a[17:16] that selects the I/O window
//   IO_UART    : UART data port (read pops the input queue, write pushes the
//                output queue)
//   IO_CLK     : cycle counter low byte (read) / program-stop port (write)
//   access_e   : what a bus transaction does, decoded from address and mem_wr
//   snap_byte  : picks one byte of the counter snapshot for 0x30005..0x30007
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef enum logic [2:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_UART_RD,
        ACC_UART_WR,
        ACC_CLK_RD,
        ACC_SNAP_RD,
        ACC_STOP_WR,
        ACC_IO_NONE
    } access_e;

    // The snapshot holds cnt[31:8]; offset 1 is its lowest byte.
    function automatic logic [7:0] snap_byte(input logic [23:0] snap,
                                             input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd1:    b = snap[7:0];
            2'd2:    b = snap[15:8];
            2'd3:    b = snap[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Byte-wide first-word-fall-through queue with synchronous active-high reset.
//   clk, rst            : clock and synchronous reset (empties the queue)
//   push, push_data     : enqueue request and data (ignored when full)
//   pop                 : dequeue request (ignored when empty)
//   head                : current head byte, 0x00 while empty
//   empty, full         : occupancy flags
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0] storage [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic do_push;
    logic do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : storage[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU byte bus: RAM with one-cycle registered
// reads, plus an I/O window at mem_a[17:16]==2'b11 holding the UART queues,
// a free-running cycle counter with coherent 32-bit readout and the
// program-stop port.
//   clk_in, rst_in            : clock, synchronous active-high reset
//   mem_a, mem_wr, mem_dout   : CPU address / write strobe / write data
//   mem_din                   : registered read data
//   rdy_out                   : CPU rdy_in; bus is only sampled when high
//   rx_valid/rx_data/rx_ready : input byte stream into the input queue
//   tx_valid/tx_data/tx_ready : output byte stream from the output queue
//   prog_stop                 : program finished and output drained
// ---------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);

    logic [7:0] ram [2**RAM_ADDR_W];

    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [17:0] io_addr;
    logic        is_io;
    logic        txn;
    access_e     access;

    logic [31:0] cnt;
    logic [23:0] snap;
    logic        stop_pend;

    logic       in_empty;
    logic       in_full;
    logic [7:0] in_head;
    logic       in_pop;

    logic       out_empty;
    logic       out_full;
    logic [7:0] out_head;
    logic       out_push;
    logic [7:0] out_push_data;

    // Address bits above 17 are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_a[31:18]};

    assign ram_addr = mem_a[RAM_ADDR_W-1:0];
    assign io_addr  = mem_a[17:0];
    assign is_io    = (mem_a[17:16] == IO_SEL);

    // Back-pressure depends only on registered state, so it moves after edges.
    assign rdy_out = !out_full && !stop_pend;
    assign txn     = rdy_out && !rst_in;

    // Classify the bus cycle once so the datapath below stays flat.
    always_comb begin
        access = ACC_IO_NONE;
        if (!is_io) begin
            access = mem_wr ? ACC_RAM_WR : ACC_RAM_RD;
        end else if (io_addr == IO_UART) begin
            access = mem_wr ? ACC_UART_WR : ACC_UART_RD;
        end else if (io_addr == IO_CLK) begin
            access = mem_wr ? ACC_STOP_WR : ACC_CLK_RD;
        end else if ((io_addr[17:2] == IO_CLK[17:2]) && !mem_wr) begin
            access = ACC_SNAP_RD;
        end
    end

    // Null bytes written to the UART port are filtered; the stop port
    // deliberately queues a 0x00 terminator.
    assign in_pop        = txn && (access == ACC_UART_RD);
    assign out_push      = txn && (((access == ACC_UART_WR) && (mem_dout != 8'h00)) ||
                                   (access == ACC_STOP_WR));
    assign out_push_data = (access == ACC_STOP_WR) ? 8'h00 : mem_dout;

    byte_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (in_pop),
        .head      (in_head),
        .empty     (in_empty),
        .full      (in_full)
    );

    byte_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (out_push),
        .push_data (out_push_data),
        .pop       (tx_ready),
        .head      (out_head),
        .empty     (out_empty),
        .full      (out_full)
    );

    assign rx_ready = !in_full;
    assign tx_valid = !out_empty;
    assign tx_data  = out_head;

    // RAM contents survive reset.
    always_ff @(posedge clk_in) begin
        if (txn && (access == ACC_RAM_WR)) ram[ram_addr] <= mem_dout;
    end

    // Read register; holds its value until the next read transaction.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (txn) begin
            case (access)
                ACC_RAM_RD:  mem_din <= ram[ram_addr];
                ACC_UART_RD: mem_din <= in_head;
                ACC_CLK_RD:  mem_din <= cnt[7:0];
                ACC_SNAP_RD: mem_din <= snap_byte(snap, io_addr[1:0]);
                ACC_IO_NONE: if (!mem_wr) mem_din <= 8'h00;
                default:     ;
            endcase
        end
    end

    // Reading the low byte freezes the upper bytes so a multi-cycle
    // 32-bit read stays coherent while the counter keeps running.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt  <= 32'd0;
            snap <= 24'd0;
        end else begin
            cnt <= cnt + 32'd1;
            if (txn && (access == ACC_CLK_RD)) snap <= cnt[31:8];
        end
    end

    // Stop is sticky; prog_stop waits until the terminator has drained.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stop_pend <= 1'b0;
            prog_stop <= 1'b0;
        end else begin
            if (txn && (access == ACC_STOP_WR)) stop_pend <= 1'b1;
            if (stop_pend && out_empty) prog_stop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Drives the responder cycle by cycle and compares every visible output
// against a queue/array reference of the bus behaviour.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int IN_DEPTH  = 16;
    localparam int OUT_DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    mem_responder #(
        .RAM_ADDR_W (17),
        .IN_DEPTH   (IN_DEPTH),
        .OUT_DEPTH  (OUT_DEPTH)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .rdy_out   (rdy_out),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .prog_stop (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    // Reference state
    byte unsigned ram_m [int];
    logic [7:0]   in_q [$];
    logic [7:0]   out_q [$];
    logic [7:0]   exp_din;
    bit           din_known;
    int unsigned  cnt_m;
    int unsigned  snap_m;
    bit           stop_m;
    bit           prog_m;

    int compared   = 0;
    int mismatched = 0;
    int tx_pct     = 50;
    int rx_pct     = 50;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        logic [7:0] head;
        head = (out_q.size() > 0) ? out_q[0] : 8'h00;
        if (din_known) checkOutput("mem_din", mem_din, exp_din);
        checkOutput("rdy_out", rdy_out, (out_q.size() < OUT_DEPTH) && !stop_m);
        checkOutput("rx_ready", rx_ready, in_q.size() < IN_DEPTH);
        checkOutput("tx_valid", tx_valid, out_q.size() > 0);
        checkOutput("tx_data", tx_data, head);
        checkOutput("prog_stop", prog_stop, prog_m);
    endtask

    // What one clock edge does to the bus-visible state.
    task automatic modelStep(input bit rst, input logic [31:0] a, input bit wr,
                             input logic [7:0] dout, input bit rxv,
                             input logic [7:0] rxd, input bit txr);
        bit rdy, in_full, new_prog, new_stop;
        logic [17:0] off;
        int key;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            exp_din   = 8'h00;
            din_known = 1'b1;
            cnt_m     = 0;
            snap_m    = 0;
            stop_m    = 1'b0;
            prog_m    = 1'b0;
            return;
        end
        rdy      = (out_q.size() < OUT_DEPTH) && !stop_m;
        in_full  = (in_q.size() == IN_DEPTH);
        new_prog = prog_m || (stop_m && out_q.size() == 0);
        new_stop = stop_m;
        if (out_q.size() > 0 && txr) void'(out_q.pop_front());
        if (rdy) begin
            off = a[17:0];
            if (off[17:16] != 2'b11) begin
                key = int'(a[16:0]);
                if (wr) begin
                    ram_m[key] = dout;
                end else if (ram_m.exists(key)) begin
                    exp_din   = ram_m[key];
                    din_known = 1'b1;
                end else begin
                    din_known = 1'b0;
                end
            end else if (wr) begin
                if (off == 18'h30000 && dout != 8'h00) begin
                    out_q.push_back(dout);
                end else if (off == 18'h30004) begin
                    out_q.push_back(8'h00);
                    new_stop = 1'b1;
                end
            end else begin
                din_known = 1'b1;
                if (off == 18'h30000) begin
                    exp_din = (in_q.size() > 0) ? in_q.pop_front() : 8'h00;
                end else if (off == 18'h30004) begin
                    exp_din = 8'(cnt_m);
                    snap_m  = cnt_m >> 8;
                end else if (off >= 18'h30005 && off <= 18'h30007) begin
                    exp_din = 8'(snap_m >> (8 * (int'(off) - 'h30005)));
                end else begin
                    exp_din = 8'h00;
                end
            end
        end
        if (rxv && !in_full) in_q.push_back(rxd);
        stop_m = new_stop;
        prog_m = new_prog;
        cnt_m  = cnt_m + 1;
    endtask

    // Drive one cycle, advance the reference, then check after the edge.
    task automatic applyStimulus(input bit rst, input logic [31:0] a, input bit wr,
                                 input logic [7:0] dout, input bit rxv,
                                 input logic [7:0] rxd, input bit txr);
        rst_in   = rst;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = dout;
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        modelStep(rst, a, wr, dout, rxv, rxd, txr);
        @(negedge clk_in);
        checkAll();
    endtask

    function automatic logic [31:0] junkHigh(input logic [17:0] low);
        logic [31:0] r;
        r = $urandom();
        return {r[31:18], low};
    endfunction

    function automatic logic [17:0] ramAddr();
        logic [16:0] low;
        low = ($urandom_range(0, 1) == 1) ? 17'h1FFF8 : 17'h00100;
        low = low + 17'($urandom_range(0, 7));
        // Bit 17 aliases only where bit 16 is clear (otherwise it is I/O).
        return {(low[16] == 1'b0) && ($urandom_range(0, 1) == 1), low};
    endfunction

    task automatic randomCycle(input logic [17:0] addr, input bit wr,
                               input logic [7:0] dout);
        bit rxv, txr;
        rxv = $urandom_range(0, 99) < rx_pct;
        txr = $urandom_range(0, 99) < tx_pct;
        applyStimulus(1'b0, junkHigh(addr), wr, dout, rxv, 8'($urandom()), txr);
    endtask

    task automatic randomOp();
        int sel;
        logic [7:0] d;
        sel = $urandom_range(0, 99);
        d   = 8'($urandom());
        if (sel < 25)      randomCycle(ramAddr(), 1'b1, d);
        else if (sel < 50) randomCycle(ramAddr(), 1'b0, d);
        else if (sel < 65) randomCycle(18'h30000, 1'b0, d);
        else if (sel < 80) randomCycle(18'h30000, 1'b1,
                                       ($urandom_range(0, 4) == 0) ? 8'h00 : d);
        else if (sel < 85) begin
            for (int i = 0; i < 4; i++) randomCycle(18'h30004 + 18'(i), 1'b0, d);
        end else if (sel < 93) begin
            case ($urandom_range(0, 2))
                0:       randomCycle(18'h30005 + 18'($urandom_range(0, 2)), 1'($urandom()), d);
                1:       randomCycle(18'h30008, 1'($urandom()), d);
                default: randomCycle(18'h3FFFF, 1'($urandom()), d);
            endcase
        end else if (sel == 93) randomCycle(18'h30004, 1'b1, d);
        else               randomCycle(ramAddr(), 1'b0, d);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        doReset();
        doReset();

        // RAM write, read and alias, then reset right after a read.
        applyStimulus(1'b0, 32'h00100, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h20100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        doReset();

        // UART input: two bytes, three reads.
        applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
        applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b1, 8'h42, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        // Push and pop together on an empty queue.
        applyStimulus(1'b0, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
        // Fill the input queue.
        for (int i = 0; i < IN_DEPTH + 2; i++)
            applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0);

        // UART output: null filter, fill, then writes while stalled.
        doReset();
        applyStimulus(1'b0, 32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < OUT_DEPTH + 3; i++)
            applyStimulus(1'b0, 32'h30000, 1'b1, 8'h31, 1'b0, 8'h00, 1'b0);

        // Coherent counter read starting at cnt == 0xFF.
        doReset();
        while (cnt_m != 32'hFF)
            applyStimulus(1'b0, 32'h00100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 32'h30004 + i, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Stop with one queued byte, then drain.
        doReset();
        applyStimulus(1'b0, 32'h30000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h30004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 32'h30000, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        doReset();

        // Randomised traffic with varying stream pressure.
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(0, 2))
                0:       tx_pct = 5;
                1:       tx_pct = 50;
                default: tx_pct = 95;
            endcase
            rx_pct = ($urandom_range(0, 1) == 1) ? 80 : 20;
            for (int n = 0; n < 250; n++) begin
                if ((prog_m && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0)
                    doReset();
                else
                    randomOp();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
